// File: rtl/wb_spi_host_pkg.sv
// Shared frame layout and state encoding for the Wishbone-to-SPI host.
// Frames carry a 24-bit header, then write data or dummy plus read data.
package wb_spi_host_pkg;

  localparam int HDR_BITS   = 24;
  localparam int DATA_BITS  = 8;
  localparam int DUMMY_BITS = 8;
  localparam int WR_BITS    = HDR_BITS + DATA_BITS;
  localparam int RD_BITS    = HDR_BITS + DUMMY_BITS + DATA_BITS;
  localparam int FRAME_W    = RD_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  // Frames are left-aligned so the engine always shifts out bit FRAME_W-1.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic        we,
    input logic [22:0] adr,
    input logic [7:0]  dat
  );
    if (we) begin
      return {we, adr, dat, 8'h00};
    end
    return {we, adr, 16'h0000};
  endfunction

endpackage

// File: rtl/wb_spi_host_shift_engine.sv
// SPI mode 0 shifter: SCK divider, bit counter and 40-bit shift register.
// Captures MISO on each rising SCK; the last 8 samples form rx_o.
import wb_spi_host_pkg::*;

module spi_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [5:0]         nbits_i,
  input  logic               miso_i,
  output logic               sck_o,
  output logic               mosi_o,
  output logic               last_o,
  output logic [7:0]         rx_o
);

  localparam logic [7:0] DIV_END = 8'(CLK_DIV - 1);

  logic               active_q, active_d;
  logic               sck_q, sck_d;
  logic [7:0]         div_q, div_d;
  logic [5:0]         bit_q, bit_d;
  logic [5:0]         nbits_q, nbits_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [7:0]         rx_q, rx_d;
  logic               div_end;

  assign div_end = (div_q == DIV_END);
  assign last_o  = active_q & sck_q & div_end
                 & (bit_q == nbits_q - 6'd1);
  assign sck_o   = sck_q;
  assign mosi_o  = active_q & sr_q[FRAME_W-1];
  assign rx_o    = rx_q;

  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    div_d    = div_q;
    bit_d    = bit_q;
    nbits_d  = nbits_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      nbits_d  = nbits_i;
      sr_d     = frame_i;
      rx_d     = '0;
    end else if (active_q) begin
      if (div_end) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[6:0], miso_i};
        end else begin
          sck_d = 1'b0;
          sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
          if (last_o) begin
            active_d = 1'b0;
            bit_d    = '0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      nbits_q  <= '0;
      sr_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      nbits_q  <= nbits_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/wb_spi_host.sv
// Wishbone slave forwarding each access as one SPI frame to a remote
// SPI-to-Wishbone bridge; FSM and bus handshake live here.
import wb_spi_host_pkg::*;

module wb_spi_host #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [22:0] adr_i,
  input  logic [7:0]  dat_i,
  output logic [7:0]  dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        spi_ss_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [8:0] GAP_END = 9'(2 * CLK_DIV - 1);

  state_e     state_q, state_d;
  logic       ss_n_q, ss_n_d;
  logic       ack_q, ack_d;
  logic [7:0] dat_q, dat_d;
  logic       we_q, we_d;
  logic       abort_q, abort_d;
  logic [8:0] gap_q, gap_d;

  logic               start;
  logic               last;
  logic [7:0]         rx;
  logic [FRAME_W-1:0] frame;
  logic [5:0]         nbits;

  assign frame = build_frame(we_i, adr_i, dat_i);
  assign nbits = we_i ? 6'(WR_BITS) : 6'(RD_BITS);

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start),
    .frame_i (frame),
    .nbits_i (nbits),
    .miso_i  (spi_miso),
    .sck_o   (spi_sck),
    .mosi_o  (spi_mosi),
    .last_o  (last),
    .rx_o    (rx)
  );

  always_comb begin
    state_d = state_q;
    ss_n_d  = ss_n_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    we_d    = we_q;
    abort_d = abort_q;
    gap_d   = gap_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
          ss_n_d  = 1'b0;
          we_d    = we_i;
          abort_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!cyc_i) begin
          abort_d = 1'b1;
        end
        if (last) begin
          state_d = ST_GAP;
          ss_n_d  = 1'b1;
          gap_d   = '0;
          // A master that left mid-frame gets no termination at all.
          ack_d   = cyc_i & ~abort_q;
          if (cyc_i && !abort_q && !we_q) begin
            dat_d = rx;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 9'd1;
        if (gap_q == GAP_END) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ss_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ss_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ss_n_q  <= ss_n_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      abort_q <= abort_d;
      gap_q   <= gap_d;
    end
  end

  assign spi_ss_n = ss_n_q;
  assign ack_o    = ack_q;
  assign dat_o    = dat_q;
  assign err_o    = 1'b0;
  assign rty_o    = 1'b0;

endmodule

// File: tb/tb_wb_spi_host.sv
// Directed bench for wb_spi_host with SPI bridge models on both instances.
// Vector table for plain accesses, hand sequences for multi-cycle cases.
module tb_wb_spi_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        cyc, stb, we;
  logic [22:0] adr;
  logic [7:0]  dat, dat_o;
  logic        ack, err, rty, ss_n, sck, mosi, miso;

  logic        cyc1, stb1, we1;
  logic [22:0] adr1;
  logic [7:0]  dat1, dat_o1;
  logic        ack1, err1, rty1, ss_n1, sck1, mosi1, miso1;

  wb_spi_host #(.CLK_DIV(2)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(dat), .dat_o(dat_o), .ack_o(ack),
    .err_o(err), .rty_o(rty), .spi_ss_n(ss_n), .spi_sck(sck),
    .spi_mosi(mosi), .spi_miso(miso)
  );

  wb_spi_host #(.CLK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc1), .stb_i(stb1), .we_i(we1),
    .adr_i(adr1), .dat_i(dat1), .dat_o(dat_o1), .ack_o(ack1),
    .err_o(err1), .rty_o(rty1), .spi_ss_n(ss_n1), .spi_sck(sck1),
    .spi_mosi(mosi1), .spi_miso(miso1)
  );

  // Bridge models: mode 0 slaves, capture MOSI and return tx on MISO.
  logic [39:0] rx0 = '0, tx0 = '0, rx1 = '0, tx1 = '0;
  int cnt0 = 0, cnt1 = 0;

  always @(negedge ss_n) begin rx0 = '0; cnt0 = 0; end
  always @(posedge sck) begin rx0 = {rx0[38:0], mosi}; cnt0++; end
  assign miso = (cnt0 < 40) ? tx0[39 - cnt0] : 1'b0;

  always @(negedge ss_n1) begin rx1 = '0; cnt1 = 0; end
  always @(posedge sck1) begin rx1 = {rx1[38:0], mosi1}; cnt1++; end
  assign miso1 = (cnt1 < 40) ? tx1[39 - cnt1] : 1'b0;

  int viol = 0;
  int ack_cnt = 0;
  always @(negedge clk) begin
    if (ss_n === 1'b1 && (sck !== 1'b0 || mosi !== 1'b0)) viol++;
    if (ss_n1 === 1'b1 && (sck1 !== 1'b0 || mosi1 !== 1'b0)) viol++;
    if (ack === 1'b1) ack_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_ack(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      if (ack === 1'b1) got = 1'b1;
      else lat++;
    end
  endtask

  typedef struct {
    logic        w;
    logic [22:0] a;
    logic [7:0]  d;
    logic [7:0]  mb;
    int          bits;
    logic [39:0] fr;
    int          lat;
    logic [7:0]  dexp;
  } vec_t;

  vec_t v[4];

  task automatic access(input vec_t t, input string tag);
    int lat;
    bit got;
    @(posedge clk);
    #1;
    tx0 = {32'h0, t.mb};
    cyc = 1'b1; stb = 1'b1; we = t.w; adr = t.a; dat = t.d;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      if (ack === 1'b1) got = 1'b1;
      else lat++;
      // Inputs wander after acceptance; the frame must not follow them.
      if (lat == 2) begin adr = ~t.a; dat = ~t.d; we = ~t.w; end
    end
    chk({tag, "_ack"}, 64'(got), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(t.lat));
    chk({tag, "_dat"}, 64'(dat_o), 64'(t.dexp));
    chk({tag, "_bits"}, 64'(cnt0), 64'(t.bits));
    chk({tag, "_frame"}, 64'(rx0), 64'(t.fr));
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk({tag, "_ackpulse"}, 64'(ack), 64'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int lat, k, a0;
    bit got;
    v[0] = '{1'b1, 23'h012345, 8'hA5, 8'h00, 32, 40'h00812345A5, 129, 8'h00};
    v[1] = '{1'b0, 23'h7FFFFF, 8'h00, 8'h3C, 40, 40'h7FFFFF0000, 161, 8'h3C};
    v[2] = '{1'b1, 23'h000000, 8'hFF, 8'h5A, 32, 40'h00800000FF, 129, 8'h3C};
    v[3] = '{1'b0, 23'h2AAAAA, 8'h11, 8'hC3, 40, 40'h2AAAAA0000, 161, 8'hC3};

    rst = 1'b1;
    cyc = 0; stb = 0; we = 0; adr = '0; dat = '0;
    cyc1 = 0; stb1 = 0; we1 = 0; adr1 = '0; dat1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 64'(ss_n), 64'd1);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_mosi", 64'(mosi), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    chk("err_rty", 64'({err, rty, err1, rty1}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) access(v[i], $sformatf("vec%0d", i));

    // Back-to-back writes with the strobe held through the gap.
    @(posedge clk);
    #1;
    tx0 = '0;
    cyc = 1; stb = 1; we = 1; adr = 23'h0ABCDE; dat = 8'h5C;
    a0 = ack_cnt;
    wait_ack(lat, got);
    chk("b2b_ack1", 64'(lat), 64'd129);
    k = 0;
    do begin @(negedge clk); k++; end while (ss_n !== 1'b0 && k < 50);
    chk("b2b_gap", 64'(k), 64'd5);
    wait_ack(lat, got);
    chk("b2b_ack2", 64'(k + lat + 1), 64'd133);
    chk("b2b_frame", 64'(rx0), 64'h8ABCDE5C);
    cyc = 0; stb = 0;
    repeat (8) @(negedge clk);
    chk("b2b_acks", 64'(ack_cnt - a0), 64'd2);

    // Master drops cyc_i at bit 10: frame finishes, no termination.
    @(posedge clk);
    #1;
    cyc = 1; stb = 1; we = 1; adr = 23'h100F0F; dat = 8'h3E;
    a0 = ack_cnt;
    repeat (42) @(negedge clk);
    cyc = 0; stb = 0;
    k = 0;
    while (ss_n !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("abort_len", 64'(k), 64'd88);
    chk("abort_bits", 64'(cnt0), 64'd32);
    chk("abort_frame", 64'(rx0), 64'h900F0F3E);
    repeat (8) @(negedge clk);
    chk("abort_noack", 64'(ack_cnt - a0), 64'd0);

    // Reset at bit 20 of a write: pins idle at once, no ack afterwards.
    @(posedge clk);
    #1;
    cyc = 1; stb = 1; we = 1; adr = 23'h055555; dat = 8'h77;
    a0 = ack_cnt;
    repeat (82) @(negedge clk);
    chk("mid_ss_low", 64'(ss_n), 64'd0);
    cyc = 0; stb = 0;
    rst = 1'b1;
    #1;
    chk("rstmid_ss_n", 64'(ss_n), 64'd1);
    chk("rstmid_sck", 64'(sck), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid_noack", 64'(ack_cnt - a0), 64'd0);
    access('{1'b1, 23'h654321, 8'h9C, 8'h00, 32, 40'h00E543219C, 129, 8'h00},
           "after_rst");

    // CLK_DIV=1 instance: 2-cycle bits, ack 65 cycles after acceptance.
    @(posedge clk);
    #1;
    tx1 = '0;
    cyc1 = 1; stb1 = 1; we1 = 1; adr1 = '0; dat1 = '0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      if (ack1 === 1'b1) got = 1'b1;
      else lat++;
    end
    chk("div1_lat", 64'(lat), 64'd65);
    chk("div1_bits", 64'(cnt1), 64'd32);
    chk("div1_frame", 64'(rx1), 64'h80000000);
    cyc1 = 0; stb1 = 0;
    @(negedge clk);
    chk("div1_ackpulse", 64'(ack1), 64'd0);
    repeat (4) @(negedge clk);

    chk("idle_pins", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
